// File: rtl/keypad_matrix_responder.sv
// keypad_matrix_responder: passive 4x4 key-matrix stand-in for the keypad scanner.
// On request it closes one contact with optional chatter, holds it, releases it
// with chatter, waits a quiet gap, then pulses done. The row path is combinational
// so the scanner sees exactly what a real passive matrix would return.
module keypad_matrix_responder #(
    parameter int DIV        = 20000,
    parameter int BOUNCES    = 2,
    parameter int HOLD_TICKS = 50,
    parameter int GAP_TICKS  = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    input  logic       req,
    input  logic [3:0] key_code,
    output logic [3:0] row,
    output logic       contact,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BOUNCE_IN = 3'd1,
        ST_HOLD      = 3'd2,
        ST_BOUNCE_OUT= 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Phase lengths in ticks; zero hold/gap lengths behave as one tick.
    localparam logic [15:0] DIV_M1      = 16'(DIV - 1);
    localparam logic [15:0] BNC_LEN_M1  = 16'(2 * BOUNCES - 1);
    localparam logic [15:0] HOLD_LEN_M1 = (HOLD_TICKS == 0) ? 16'd0 : 16'(HOLD_TICKS - 1);
    localparam logic [15:0] GAP_LEN_M1  = (GAP_TICKS == 0) ? 16'd0 : 16'(GAP_TICKS - 1);
    localparam bit          HAS_BOUNCE  = (BOUNCES > 0);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] presc_r;
    logic [15:0] bcnt_r;
    logic [15:0] bcnt_nxt_s;
    logic [3:0]  key_r;
    logic        contact_r;
    logic        busy_r;
    logic        done_r;
    logic        contact_nxt_s;
    logic        busy_nxt_s;
    logic        done_nxt_s;
    logic        tick_s;
    logic        accept_s;
    logic [3:0]  row_s;

    assign tick_s   = (presc_r == DIV_M1);
    assign accept_s = (state_r == ST_IDLE) && req;

    // Next-state and tick-count logic; the tick count clears on every state change.
    always_comb begin
        state_nxt_s = state_r;
        bcnt_nxt_s  = bcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_nxt_s = HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
                    bcnt_nxt_s  = 16'd0;
                end else begin
                    bcnt_nxt_s  = 16'd0;
                end
            end
            ST_BOUNCE_IN: begin
                if (tick_s && (bcnt_r == BNC_LEN_M1)) begin
                    state_nxt_s = ST_HOLD;
                    bcnt_nxt_s  = 16'd0;
                end else if (tick_s) begin
                    bcnt_nxt_s  = bcnt_r + 16'd1;
                end else begin
                    bcnt_nxt_s  = bcnt_r;
                end
            end
            ST_HOLD: begin
                if (tick_s && (bcnt_r == HOLD_LEN_M1)) begin
                    state_nxt_s = HAS_BOUNCE ? ST_BOUNCE_OUT : ST_GAP;
                    bcnt_nxt_s  = 16'd0;
                end else if (tick_s) begin
                    bcnt_nxt_s  = bcnt_r + 16'd1;
                end else begin
                    bcnt_nxt_s  = bcnt_r;
                end
            end
            ST_BOUNCE_OUT: begin
                if (tick_s && (bcnt_r == BNC_LEN_M1)) begin
                    state_nxt_s = ST_GAP;
                    bcnt_nxt_s  = 16'd0;
                end else if (tick_s) begin
                    bcnt_nxt_s  = bcnt_r + 16'd1;
                end else begin
                    bcnt_nxt_s  = bcnt_r;
                end
            end
            ST_GAP: begin
                if (tick_s && (bcnt_r == GAP_LEN_M1)) begin
                    state_nxt_s = ST_DONE;
                    bcnt_nxt_s  = 16'd0;
                end else if (tick_s) begin
                    bcnt_nxt_s  = bcnt_r + 16'd1;
                end else begin
                    bcnt_nxt_s  = bcnt_r;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                bcnt_nxt_s  = 16'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                bcnt_nxt_s  = 16'd0;
            end
        endcase
    end

    // Output decode from the next state so contact/busy/done can be registered without lag.
    always_comb begin
        contact_nxt_s = 1'b0;
        busy_nxt_s    = 1'b0;
        done_nxt_s    = 1'b0;
        case (state_nxt_s)
            ST_BOUNCE_IN: begin
                contact_nxt_s = ~bcnt_nxt_s[0];
                busy_nxt_s    = 1'b1;
            end
            ST_HOLD: begin
                contact_nxt_s = 1'b1;
                busy_nxt_s    = 1'b1;
            end
            ST_BOUNCE_OUT: begin
                contact_nxt_s = bcnt_nxt_s[0];
                busy_nxt_s    = 1'b1;
            end
            ST_GAP: begin
                busy_nxt_s    = 1'b1;
            end
            ST_DONE: begin
                done_nxt_s    = 1'b1;
            end
            default: begin
                contact_nxt_s = 1'b0;
            end
        endcase
    end

    // State, tick count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bcnt_r    <= 16'd0;
            contact_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bcnt_r    <= bcnt_nxt_s;
            contact_r <= contact_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    // Tick prescaler; restarted on accept so each phase is a whole number of ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= 16'd0;
        end else if (accept_s || tick_s) begin
            presc_r <= 16'd0;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    // Key latch; holds the accepted position until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r <= 4'd0;
        end else if (accept_s) begin
            key_r <= key_code;
        end else begin
            key_r <= key_r;
        end
    end

    // Passive matrix: the closed contact pulls its row low only while its column is driven.
    // Bit 3 is index 0 on both buses, so index i maps to bit ~i.
    always_comb begin
        row_s = 4'b1111;
        if (contact_r && !col[~key_r[1:0]]) begin
            row_s[~key_r[3:2]] = 1'b0;
        end else begin
            row_s = 4'b1111;
        end
    end

    assign row     = row_s;
    assign contact = contact_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule
